// File: rtl/via_pkg.sv
// Shared definitions for the 6522-style timer/interrupt responder.
// Register offsets, interrupt bit positions and the bus access bundle.
package via_pkg;

  localparam logic [3:0] VIA_T1CL = 4'h4;
  localparam logic [3:0] VIA_T1CH = 4'h5;
  localparam logic [3:0] VIA_T1LL = 4'h6;
  localparam logic [3:0] VIA_T1LH = 4'h7;
  localparam logic [3:0] VIA_T2CL = 4'h8;
  localparam logic [3:0] VIA_T2CH = 4'h9;
  localparam logic [3:0] VIA_ACR  = 4'hB;
  localparam logic [3:0] VIA_IFR  = 4'hD;
  localparam logic [3:0] VIA_IER  = 4'hE;

  localparam int IRQ_T1         = 6;
  localparam int IRQ_T2         = 5;
  localparam int ACR_T1_FREERUN = 6;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [3:0] rs;
    logic [7:0] wdata;
  } via_acc_t;

endpackage

// File: rtl/via_timer16.sv
// 16-bit interval timer: counter, reload latch and armed bit.
// zero_event pulses on a tick that finds an armed counter at zero.
module via_timer16
  import via_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        free_run,
  input  logic [1:0]  latch_we,
  input  logic [7:0]  wdata,
  output logic [15:0] count,
  output logic [15:0] latch,
  output logic        zero_event
);

  logic [15:0] count_q, count_d;
  logic [15:0] latch_q, latch_d;
  logic        armed_q, armed_d;

  always_comb begin
    count_d    = count_q;
    latch_d    = latch_q;
    armed_d    = armed_q;
    zero_event = 1'b0;
    if (latch_we[0]) latch_d[7:0]  = wdata;
    if (latch_we[1]) latch_d[15:8] = wdata;
    // a load always lands on a tick and beats the countdown
    if (load) begin
      count_d = load_value;
      armed_d = 1'b1;
    end else if (tick) begin
      if (count_q != 16'h0000) begin
        count_d = count_q - 16'd1;
      end else begin
        zero_event = armed_q;
        if (free_run) begin
          count_d = latch_q;
        end else begin
          count_d = 16'hFFFF;
          armed_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      latch_q <= '0;
      armed_q <= 1'b0;
    end else begin
      count_q <= count_d;
      latch_q <= latch_d;
      armed_q <= armed_d;
    end
  end

  assign count = count_q;
  assign latch = latch_q;

endmodule

// File: rtl/via_timer_responder.sv
// 6502 bus responder with two interval timers, IFR, IER and ACR.
// All register side-effects commit on the falling edge of PHI_2.
module via_timer_responder
  import via_pkg::*;
#(
  parameter logic [7:0] ACR_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       nRES,
  input  logic       PHI_2,
  input  logic       nCS,
  input  logic [3:0] RS,
  input  logic       RnW,
  inout  wire  [7:0] Data_bus,
  output logic       nIRQ
);

  logic       phi_q, phi_d;
  logic [7:0] acr_q, acr_d;
  logic [6:5] ifr_q, ifr_d;
  logic [6:5] ier_q, ier_d;

  logic       tick;
  via_acc_t   acc;
  logic       irq_any;
  logic [7:0] rdata;

  logic wr_t1cl, wr_t1ch, wr_t1ll, wr_t1lh;
  logic wr_t2cl, wr_t2ch;
  logic wr_acr, wr_ifr, wr_ier;
  logic rd_t1cl, rd_t2cl;
  logic clr_t1, clr_t2;

  logic [15:0] t1_count, t1_latch;
  logic [15:0] t2_count, t2_latch;
  logic        t1_zero, t2_zero;
  logic        unused_t2_hi;

  assign phi_d = PHI_2;
  assign tick  = phi_q & ~PHI_2;

  assign acc.rd    = tick & ~nCS & RnW;
  assign acc.wr    = tick & ~nCS & ~RnW;
  assign acc.rs    = RS;
  assign acc.wdata = Data_bus;

  assign wr_t1cl = acc.wr & (acc.rs == VIA_T1CL);
  assign wr_t1ch = acc.wr & (acc.rs == VIA_T1CH);
  assign wr_t1ll = acc.wr & (acc.rs == VIA_T1LL);
  assign wr_t1lh = acc.wr & (acc.rs == VIA_T1LH);
  assign wr_t2cl = acc.wr & (acc.rs == VIA_T2CL);
  assign wr_t2ch = acc.wr & (acc.rs == VIA_T2CH);
  assign wr_acr  = acc.wr & (acc.rs == VIA_ACR);
  assign wr_ifr  = acc.wr & (acc.rs == VIA_IFR);
  assign wr_ier  = acc.wr & (acc.rs == VIA_IER);
  assign rd_t1cl = acc.rd & (acc.rs == VIA_T1CL);
  assign rd_t2cl = acc.rd & (acc.rs == VIA_T2CL);

  via_timer16 u_t1 (
    .clk        (clk),
    .rst_n      (nRES),
    .tick       (tick),
    .load       (wr_t1ch),
    .load_value ({acc.wdata, t1_latch[7:0]}),
    .free_run   (acr_q[ACR_T1_FREERUN]),
    .latch_we   ({wr_t1ch | wr_t1lh,
                  wr_t1cl | wr_t1ll}),
    .wdata      (acc.wdata),
    .count      (t1_count),
    .latch      (t1_latch),
    .zero_event (t1_zero)
  );

  via_timer16 u_t2 (
    .clk        (clk),
    .rst_n      (nRES),
    .tick       (tick),
    .load       (wr_t2ch),
    .load_value ({acc.wdata, t2_latch[7:0]}),
    .free_run   (1'b0),
    .latch_we   ({1'b0, wr_t2cl}),
    .wdata      (acc.wdata),
    .count      (t2_count),
    .latch      (t2_latch),
    .zero_event (t2_zero)
  );

  assign unused_t2_hi = ^t2_latch[15:8];

  assign clr_t1 = rd_t1cl | wr_t1ch | wr_t1lh
                | (wr_ifr & acc.wdata[IRQ_T1]);
  assign clr_t2 = rd_t2cl | wr_t2ch
                | (wr_ifr & acc.wdata[IRQ_T2]);

  always_comb begin
    acr_d = acr_q;
    ier_d = ier_q;
    ifr_d = ifr_q;
    if (wr_acr) acr_d = acc.wdata;
    if (wr_ier) begin
      if (acc.wdata[7]) ier_d = ier_q | acc.wdata[6:5];
      else              ier_d = ier_q & ~acc.wdata[6:5];
    end
    // a flag being set outranks a clear on the same tick
    ifr_d[IRQ_T1] = t1_zero | (ifr_q[IRQ_T1] & ~clr_t1);
    ifr_d[IRQ_T2] = t2_zero | (ifr_q[IRQ_T2] & ~clr_t2);
  end

  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      phi_q <= 1'b0;
      acr_q <= ACR_RESET;
      ier_q <= '0;
      ifr_q <= '0;
    end else begin
      phi_q <= phi_d;
      acr_q <= acr_d;
      ier_q <= ier_d;
      ifr_q <= ifr_d;
    end
  end

  assign irq_any = |(ifr_q & ier_q);
  assign nIRQ    = ~irq_any;

  always_comb begin
    rdata = 8'h00;
    unique case (1'b1)
      RS == VIA_T1CL: rdata = t1_count[7:0];
      RS == VIA_T1CH: rdata = t1_count[15:8];
      RS == VIA_T1LL: rdata = t1_latch[7:0];
      RS == VIA_T1LH: rdata = t1_latch[15:8];
      RS == VIA_T2CL: rdata = t2_count[7:0];
      RS == VIA_T2CH: rdata = t2_count[15:8];
      RS == VIA_ACR:  rdata = acr_q;
      RS == VIA_IFR:  rdata = {irq_any, ifr_q, 5'b0};
      RS == VIA_IER:  rdata = {1'b1, ier_q, 5'b0};
      default:        rdata = 8'h00;
    endcase
  end

  assign Data_bus = (~nCS & RnW & PHI_2) ? rdata : 8'hzz;

endmodule

// File: tb/tb_via_timer_responder.sv
// Directed bench for via_timer_responder: table of bus cycles
// plus hand sequences for reset mid-countdown and bus release.
module tb_via_timer_responder;

  logic       clk;
  logic       nRES;
  logic       PHI_2;
  logic       nCS;
  logic [3:0] RS;
  logic       RnW;
  wire  [7:0] Data_bus;
  logic       nIRQ;

  logic       tb_oe;
  logic [7:0] tb_drv;

  int checks;
  int errors;

  assign Data_bus = tb_oe ? tb_drv : 8'hzz;

  via_timer_responder #(.ACR_RESET(8'h00)) dut (
    .clk      (clk),
    .nRES     (nRES),
    .PHI_2    (PHI_2),
    .nCS      (nCS),
    .RS       (RS),
    .RnW      (RnW),
    .Data_bus (Data_bus),
    .nIRQ     (nIRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [3:0] rs;
    logic       rnw;
    logic [7:0] wd;
    logic       chk;
    logic [7:0] exp;
    logic       irq;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t W(input logic [3:0] rs,
                             input logic [7:0] d,
                             input logic irq);
    vec_t v;
    v = '{1'b1, rs, 1'b0, d, 1'b0, 8'h00, irq};
    return v;
  endfunction

  function automatic vec_t R(input logic [3:0] rs,
                             input logic [7:0] e,
                             input logic irq);
    vec_t v;
    v = '{1'b1, rs, 1'b1, 8'h00, 1'b1, e, irq};
    return v;
  endfunction

  function automatic vec_t I(input logic irq);
    vec_t v;
    v = '{1'b0, 4'h0, 1'b1, 8'h00, 1'b0, 8'h00, irq};
    return v;
  endfunction

  task automatic chk8(input string name,
                      input logic [7:0] act,
                      input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h",
               name, act, exp);
    end
  endtask

  // one bus cycle: PHI_2 high for a clk, then low; tick on next edge
  task automatic bus(input  logic       sel,
                     input  logic [3:0] rs,
                     input  logic       rnw,
                     input  logic [7:0] wd,
                     output logic [7:0] rd,
                     output logic       irq);
    @(negedge clk);
    nCS    = ~sel;
    RS     = rs;
    RnW    = rnw;
    tb_drv = wd;
    tb_oe  = sel & ~rnw;
    PHI_2  = 1'b1;
    @(negedge clk);
    rd    = Data_bus;
    PHI_2 = 1'b0;
    @(posedge clk);
    #1;
    irq   = nIRQ;
    nCS   = 1'b1;
    RnW   = 1'b1;
    tb_oe = 1'b0;
  endtask

  task automatic run(input vec_t v, input string tag);
    logic [7:0] rd;
    logic       irq;
    bus(v.sel, v.rs, v.rnw, v.wd, rd, irq);
    if (v.chk) chk8({tag, "_rd"}, rd, v.exp);
    chk8({tag, "_irq"}, {7'b0, irq}, {7'b0, v.irq});
  endtask

  initial begin
    logic [3:0] rr [9];
    logic [7:0] re [9];
    checks = 0;
    errors = 0;
    nRES   = 1'b0;
    PHI_2  = 1'b0;
    nCS    = 1'b1;
    RS     = 4'h0;
    RnW    = 1'b1;
    tb_oe  = 1'b0;
    tb_drv = 8'h00;

    // T1 one-shot from 0003, read-clear, wrap values
    tbl.push_back(W(4'hE, 8'hC0, 1'b1));
    tbl.push_back(W(4'h6, 8'h03, 1'b1));
    tbl.push_back(W(4'h5, 8'h00, 1'b1));
    tbl.push_back(R(4'h4, 8'h03, 1'b1));
    tbl.push_back(R(4'h5, 8'h00, 1'b1));
    tbl.push_back(R(4'h4, 8'h01, 1'b1));
    tbl.push_back(I(1'b0));
    tbl.push_back(R(4'hD, 8'hC0, 1'b0));
    tbl.push_back(R(4'h4, 8'hFE, 1'b1));
    tbl.push_back(R(4'h5, 8'hFF, 1'b1));
    tbl.push_back(R(4'h4, 8'hFC, 1'b1));
    tbl.push_back(R(4'hD, 8'h00, 1'b1));
    // T1 free-run, latch 0002: flag every third tick
    tbl.push_back(W(4'hB, 8'h40, 1'b1));
    tbl.push_back(W(4'h6, 8'h02, 1'b1));
    tbl.push_back(W(4'h5, 8'h00, 1'b1));
    tbl.push_back(I(1'b1));
    tbl.push_back(I(1'b1));
    tbl.push_back(I(1'b0));
    tbl.push_back(W(4'hD, 8'h40, 1'b1));
    tbl.push_back(I(1'b1));
    tbl.push_back(I(1'b0));
    tbl.push_back(R(4'hD, 8'hC0, 1'b0));
    tbl.push_back(W(4'hD, 8'h40, 1'b1));
    tbl.push_back(I(1'b0));
    tbl.push_back(W(4'h7, 8'h00, 1'b1));
    tbl.push_back(I(1'b1));
    // reload on the zero tick: load wins, no flag
    tbl.push_back(W(4'h5, 8'h00, 1'b1));
    tbl.push_back(R(4'h4, 8'h02, 1'b1));
    tbl.push_back(R(4'hD, 8'h00, 1'b1));
    // read-clear on the zero tick: set wins
    tbl.push_back(R(4'h4, 8'h00, 1'b0));
    tbl.push_back(R(4'hD, 8'hC0, 1'b0));
    tbl.push_back(W(4'hB, 8'h00, 1'b0));
    tbl.push_back(W(4'hD, 8'h40, 1'b0));
    tbl.push_back(W(4'hD, 8'h40, 1'b1));
    tbl.push_back(R(4'hD, 8'h00, 1'b1));
    // T2 with IER disabled, then enabled
    tbl.push_back(W(4'hE, 8'h60, 1'b1));
    tbl.push_back(R(4'hE, 8'h80, 1'b1));
    tbl.push_back(W(4'h8, 8'h05, 1'b1));
    tbl.push_back(W(4'h9, 8'h00, 1'b1));
    tbl.push_back(R(4'h8, 8'h05, 1'b1));
    tbl.push_back(R(4'h9, 8'h00, 1'b1));
    tbl.push_back(I(1'b1));
    tbl.push_back(I(1'b1));
    tbl.push_back(I(1'b1));
    tbl.push_back(I(1'b1));
    tbl.push_back(R(4'hD, 8'h20, 1'b1));
    tbl.push_back(W(4'hE, 8'hA0, 1'b0));
    tbl.push_back(R(4'hD, 8'hA0, 1'b0));
    tbl.push_back(R(4'hE, 8'hA0, 1'b0));
    tbl.push_back(W(4'hD, 8'h20, 1'b1));
    // IFR clear write on the T2 zero tick
    tbl.push_back(W(4'h8, 8'h01, 1'b1));
    tbl.push_back(W(4'h9, 8'h00, 1'b1));
    tbl.push_back(I(1'b1));
    tbl.push_back(W(4'hD, 8'h20, 1'b0));
    tbl.push_back(R(4'hD, 8'hA0, 1'b0));
    tbl.push_back(R(4'h8, 8'hFE, 1'b1));
    // unmapped registers
    tbl.push_back(W(4'h1, 8'hFF, 1'b1));
    tbl.push_back(W(4'hF, 8'hFF, 1'b1));
    tbl.push_back(R(4'h1, 8'h00, 1'b1));
    tbl.push_back(R(4'hF, 8'h00, 1'b1));
    tbl.push_back(R(4'hB, 8'h00, 1'b1));
    tbl.push_back(R(4'hE, 8'hA0, 1'b1));
    tbl.push_back(R(4'hD, 8'h00, 1'b1));
    tbl.push_back(R(4'h6, 8'h02, 1'b1));
    tbl.push_back(R(4'h7, 8'h00, 1'b1));

    repeat (3) @(negedge clk);
    chk8("rst_nirq", {7'b0, nIRQ}, 8'h01);
    nRES = 1'b1;

    foreach (tbl[i]) run(tbl[i], $sformatf("v%0d", i));

    // free-run T1 with IFR6 set, then async reset
    run(W(4'hB, 8'h40, 1'b1), "mr_acr");
    run(W(4'hE, 8'hC0, 1'b1), "mr_ier");
    run(W(4'h6, 8'h01, 1'b1), "mr_ll");
    run(W(4'h5, 8'h00, 1'b1), "mr_ld");
    run(I(1'b1), "mr_t0");
    run(I(1'b0), "mr_t1");
    #2;
    nRES = 1'b0;
    #1;
    chk8("mr_async_nirq", {7'b0, nIRQ}, 8'h01);
    rr = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
           4'h9, 4'hB, 4'hD, 4'hE};
    re = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h80};
    for (int k = 0; k < 9; k++)
      run(R(rr[k], re[k], 1'b1), $sformatf("mr_rd%0d", k));
    @(negedge clk);
    nRES = 1'b1;
    run(I(1'b1), "mr_idle");
    run(R(4'hD, 8'h00, 1'b1), "mr_ifr");
    run(R(4'hB, 8'h00, 1'b1), "mr_acr_rd");

    // bus release: bench drives 5A wherever the DUT must let go
    @(negedge clk);
    RS     = 4'hE;
    tb_drv = 8'h5A;
    tb_oe  = 1'b1;
    nCS    = 1'b1;
    RnW    = 1'b1;
    PHI_2  = 1'b1;
    #1;
    chk8("bus_ncs", Data_bus, 8'h5A);
    nCS   = 1'b0;
    PHI_2 = 1'b0;
    #1;
    chk8("bus_phi", Data_bus, 8'h5A);
    RnW   = 1'b0;
    PHI_2 = 1'b1;
    #1;
    chk8("bus_wr", Data_bus, 8'h5A);
    PHI_2 = 1'b0;
    nCS   = 1'b1;
    RnW   = 1'b1;
    tb_oe = 1'b0;
    @(negedge clk);
    nCS   = 1'b0;
    PHI_2 = 1'b1;
    #1;
    chk8("bus_rd", Data_bus, 8'h80);
    PHI_2 = 1'b0;
    nCS   = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
